fifo_buffer: RTL and testbench
==============================

# fifo_buffer

Synchronous single-clock FIFO, 8 entries × 8 bits, with registered read data and occupancy count. It sits between a producer and a consumer in the same clock domain. It provides `full`/`empty` back-pressure flags and a live `count` for flow control. Push and pop may occur in the same cycle.

## Interface
- `DATA_W`, 8, width of each stored word.
- `ADDR_W`, 3, pointer width; depth = 2^ADDR_W.
- `DEPTH`, 8, number of entries; always equals 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  write request; `data_in` is captured on the edge when the request is accepted.
- `pop`  in  1  read request; the head word is transferred to `data_out` on the edge when the request is accepted.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data; holds the last popped word.
- `full`  out  1  high when count == DEPTH.
- `empty`  out  1  high when count == 0.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.

## Operation
- State: storage array, write pointer `wr_ptr` (ADDR_W bits), read pointer `rd_ptr` (ADDR_W bits), `count` register, `data_out` register.
- Accept rules:
  - `do_pop = pop && !empty`.
  - `do_push = push && (!full || do_pop)`. A push while full is accepted only when a pop is accepted in the same cycle.
- On `do_push`: `mem[wr_ptr] <= data_in`; `wr_ptr` increments modulo DEPTH and wraps naturally from 7 to 0.
- On `do_pop`: `data_out <= mem[rd_ptr]`; `rd_ptr` increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both accepted: unchanged.
  - neither accepted: unchanged.
- Push+pop while empty: only the push is accepted (no read-through); `count` becomes 1; `data_out` is unchanged.
- Ignored requests (push while full without pop, pop while empty) change no state, including `data_out`.
- Ordering is strict FIFO.

## Timing
- Reset (`rst` high at an edge) forces:
  - `wr_ptr = 0`, `rd_ptr = 0`, `count = 0`, `data_out = 0`.
  - Outputs therefore read `empty = 1`, `full = 0`.
  - Storage contents are not reset.
  - Reset overrides any concurrent push/pop.
  - A reset mid-operation discards all stored data.
- Read latency: `data_out` shows the popped word one edge after `pop` is sampled high.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 at the earliest.
- `full`, `empty` and `count` update on the same edge as the accepted operation.
- `full` and `empty` are decoded from the registered `count`; there is no combinational path from `push`/`pop` to any output.

## Configuration
- Macro `FIFO_BUFFER_ERR_FLAGS_EN`.
- When defined, two additional outputs are added:
  - `overflow`: 1-cycle registered pulse when `push && full && !do_pop`.
  - `underflow`: 1-cycle registered pulse when `pop && empty`.
  - Both reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical in both builds.

## Structure
- Package `fifo_buffer_pkg` holds `DATA_W`, `ADDR_W`, `DEPTH` defaults and the typedefs `data_t` (DATA_W bits) and `ptr_t` (ADDR_W bits).
- Sub-module `fifo_buffer_mem`: DEPTH×DATA_W array with one synchronous write port and one synchronous registered read port with read-enable.
- Pointers, count and flag logic live in the top level.

## Test plan
- Reset: hold `rst` for 2 cycles → `count = 0`, `empty = 1`, `full = 0`, `data_out = 0`.
- Fill: 8 pushes of 1..8, then a push of 0xFF while full → `count` reaches 8 and `full = 1`; 0xFF is dropped; `count` stays 8.
- Partial drain: 3 pops → `data_out` = 1, 2, 3 in turn; `count = 5`; `full = 0`.
- Wrap: push 9, 10 → `count = 7`; `wr_ptr` has wrapped past 7.
- Simultaneous: 5 cycles of push+pop with `data_in` 0x14..0x18 → `data_out` = 4, 5, 6, 7, 8; `count` stays 7.
- Drain and edge cases:
  - Pop until empty → `data_out` = 9, 0x0A, 0x14..0x18; `empty = 1`.
  - A further pop leaves `data_out = 0x18` and `count = 0`.
  - Push+pop while empty → `count = 1`.
  - Reset asserted mid-fill → empty.

Source files
------------

// File: rtl/fifo_buffer_pkg.sv
// fifo_buffer_pkg: shared widths and types for the fifo_buffer block
package fifo_buffer_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_buffer_mem.sv
// fifo_buffer_mem: DEPTH x DATA_W storage, sync write port, registered read port with enable
module fifo_buffer_mem
    import fifo_buffer_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [1<<AW];
    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= wdata;
    // only the read register is reset; the array keeps stale contents
    always_ff @(posedge clk)
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: 8x8 single-clock FIFO with registered read data and occupancy count
// Optional FIFO_BUFFER_ERR_FLAGS_EN adds registered overflow/underflow pulses.
module fifo_buffer
    import fifo_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  data_t             data_in,
    output data_t             data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    ptr_t wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (ADDR_W+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(do_push);
            rd_ptr <= rd_ptr + ptr_t'(do_pop);
            count  <= count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        end
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    always_ff @(posedge clk)
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && full && !do_pop;
            underflow <= pop && empty;
        end
`endif
    fifo_buffer_mem #(.DW(DATA_W), .AW(ADDR_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (do_pop),
        .raddr (rd_ptr),
        .rdata (data_out)
    );
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: scoreboard bench for fifo_buffer
module tb_fifo_buffer;
    logic       clk = 0, rst = 1, push = 0, pop = 0;
    logic [7:0] data_in = 0, data_out;
    logic       full, empty;
    logic [3:0] count;
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif
    int         n_checks = 0, n_fail = 0;
    logic [7:0] sb[$];
    logic [7:0] m_dout;
    fifo_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_state(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(sb.size() == 8));
    endtask
    task automatic op(input string tag, input logic p, input logic q, input logic [7:0] d);
        logic mpop, mpush, was_full, was_empty;
        push = p; pop = q; data_in = d;
        was_full  = sb.size() == 8;
        was_empty = sb.size() == 0;
        mpop  = q && !was_empty;
        mpush = p && (!was_full || mpop);
        @(posedge clk); #1;
        push = 0; pop = 0;
        if (mpop) m_dout = sb.pop_front();
        if (mpush) sb.push_back(d);
        check_state(tag);
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(p && was_full && !mpop));
        check({tag, ".underflow"}, 32'(underflow), 32'(q && was_empty));
`endif
    endtask
    task automatic do_reset(input logic p, input logic [7:0] d);
        rst = 1; push = p; data_in = d;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; push = 0;
        sb.delete();
        m_dout = 0;
        check_state("reset");
    endtask
    initial begin
        m_dout = 0;
        do_reset(0, 0);
        for (int i = 1; i <= 8; i++) op("fill", 1, 0, 8'(i));
        check("fill.full", 32'(full), 1);
        op("push_full", 1, 0, 8'hFF);
        check("push_full.count", 32'(count), 8);
        for (int i = 1; i <= 3; i++) begin
            op("drain3", 0, 1, 0);
            check("drain3.val", 32'(data_out), 32'(i));
        end
        op("wrap", 1, 0, 8'h09);
        op("wrap", 1, 0, 8'h0A);
        check("wrap.count", 32'(count), 7);
        for (int i = 0; i < 5; i++) begin
            op("simul", 1, 1, 8'(8'h14 + i));
            check("simul.val", 32'(data_out), 32'(4 + i));
        end
        while (!empty && n_checks < 10000) op("drain", 0, 1, 0);
        check("drain.last", 32'(data_out), 32'h18);
        op("pop_empty", 0, 1, 0);
        check("pop_empty.hold", 32'(data_out), 32'h18);
        op("pushpop_empty", 1, 1, 8'h55);
        check("pushpop_empty.count", 32'(count), 1);
        op("midfill", 1, 0, 8'h66);
        op("midfill", 1, 0, 8'h77);
        do_reset(1, 8'h88);
        check("midfill.empty", 32'(empty), 1);
        for (int i = 0; i < 400; i++)
            op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
